// File: rtl/mdu_ctrl_if.sv
// Command/result bundle between the EX stage and the multiply/divide sequencer.
// master = pipeline side, slave = mdu_ctrl.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, Src1, Src2, input busy, hi, lo);
    modport slave  (input start, op, Src1, Src2, output busy, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer: result computed at accept, HI/LO committed after a fixed busy window.
// Optional macro MDU_FLUSH_EN adds a flush input that aborts an in-flight operation.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      rst_n,
`ifdef MDU_FLUSH_EN
    input  logic      flush,
`endif
    mdu_ctrl_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic        pend_skip_q;

    logic        flush_w;
    logic        a_neg, b_neg, div_zero_d;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [63:0] prod_d;
    logic [31:0] res_hi_d, res_lo_d;

`ifdef MDU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        a_neg      = (bus.op == OP_DIV) && bus.Src1[31];
        b_neg      = (bus.op == OP_DIV) && bus.Src2[31];
        a_mag      = a_neg ? (~bus.Src1 + 32'd1) : bus.Src1;
        b_mag      = b_neg ? (~bus.Src2 + 32'd1) : bus.Src2;
        div_zero_d = (bus.Src2 == 32'd0);
        q_mag      = div_zero_d ? 32'd0 : a_mag / b_mag;
        r_mag      = div_zero_d ? 32'd0 : a_mag % b_mag;
        prod_d     = 64'd0;
        if (bus.op == OP_MULT)
            prod_d = {{32{bus.Src1[31]}}, bus.Src1} * {{32{bus.Src2[31]}}, bus.Src2};
        else if (bus.op == OP_MULTU)
            prod_d = {32'd0, bus.Src1} * {32'd0, bus.Src2};
        res_hi_d = prod_d[63:32];
        res_lo_d = prod_d[31:0];
        if (bus.op == OP_DIV || bus.op == OP_DIVU) begin
            res_lo_d = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
            res_hi_d = a_neg ? (~r_mag + 32'd1) : r_mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_skip_q <= 1'b0;
        end else if (flush_w) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_skip_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_q   <= res_hi_d;
                                pend_lo_q   <= res_lo_d;
                                pend_skip_q <= 1'b0;
                                cnt_q       <= MULT_LOAD;
                                state_q     <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_q   <= res_hi_d;
                                pend_lo_q   <= res_lo_d;
                                pend_skip_q <= div_zero_d;
                                cnt_q       <= DIV_LOAD;
                                state_q     <= RUN;
                            end
                            OP_MTHI: hi_q <= bus.Src1;
                            OP_MTLO: lo_q <= bus.Src1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt_q == 4'd0) begin
                        if (!pend_skip_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

`ifndef SYNTHESIS
    // Upstream must stall while busy; such a start is dropped.
    stall_violation: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.start && state_q == RUN))
        else $warning("mdu_ctrl: start while busy ignored (upstream stall violation)");
`endif

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit sequencer for the EX stage, alongside the single-cycle ALU.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per idle cycle.
- Computes the result, holds busy for a fixed latency, then commits HI/LO.
- The pipeline stalls on busy. It also stalls when an MDU command sits in the D stage while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  command valid, single-cycle pulse from EX.
- op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
- Src1  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- Src2  input  32  rt operand: multiplier or divisor.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: rst_n low asynchronously clears state to IDLE, counter=0, busy=0, hi=0, lo=0, and the pending result registers to 0.
- Reset mid-RUN aborts the operation. Nothing is committed.
- States: IDLE, RUN.
- Accept condition: start=1, state IDLE, op in 1..4. At that edge (E0):
  - The full result goes into pend_hi/pend_lo.
  - The counter loads N-1, where N=MULT_CYCLES or DIV_CYCLES.
  - State goes to RUN.
- RUN: busy=1 from the cycle after E0 for exactly N cycles. The counter decrements each edge. On the edge where counter==0 in RUN:
  - hi<=pend_hi, lo<=pend_lo, busy drops, state returns to IDLE.
  - The new hi/lo are visible in the same cycle busy reads 0.
- busy is a registered output equal to (state==RUN). No combinational path exists from start to busy.
- MTHI/MTLO (op 5/6), start=1, IDLE: hi (or lo) <= Src1 at that edge. No busy cycles.
- Any start while in RUN is ignored. This is an upstream stall violation and is flagged by an assertion in simulation only.
- op 0/7 with start=1: no effect.
- MULT: {hi,lo} = signed 64-bit product of Src1 and Src2.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divisor 0 (DIV/DIVU): the busy sequence runs normally; at completion hi/lo stay unchanged.
- Operands are sampled only at E0. Src1/Src2 changes during RUN have no effect.
- A start in the same cycle busy falls (IDLE that cycle) is accepted normally. This gives back-to-back operations with one idle cycle between busy windows.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- When defined, the block adds input port flush (1 bit). flush=1 has priority over start at any edge:
  - In RUN: state goes to IDLE, counter goes to 0, busy drops next cycle, pend results are discarded, hi/lo are unchanged.
  - In IDLE: a simultaneous start is ignored.
- Used for exception/eret flush of an in-flight MDU instruction.
- When undefined: no flush port, and the behaviour above is unaffected.

Test Plan:
- Reset: rst_n=0 mid-run → busy=0, hi=lo=0 immediately without a clock edge. Release rst_n, then MTLO 0x12345678 → lo=0x12345678 next cycle, busy never rises.
- MULT, Src1=0xFFFFFFFE (-2), Src2=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV, Src1=0xFFFFFFF9 (-7), Src2=2 → busy exactly 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2 → lo=3, hi=1.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero with hi=0xAAAA0000, lo=0x0000BBBB preloaded via MTHI/MTLO → busy 10 cycles, then hi/lo unchanged.
- MULT started, then start=1 with op=MTHI, Src1=0xDEADBEEF at cycle 2 of busy → ignored; final hi/lo equal the MULT result. A new MULT issued in the cycle busy falls → accepted, busy rises again next cycle.
- MDU_FLUSH_EN: DIV 100/7 with flush at busy cycle 4 → busy=0 next cycle, hi/lo keep their prior values. A subsequent MULTU 6*7 → lo=42, hi=0.
